i2s_tx_framer: RTL



---
 rtl/i2s_tx_framer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_framer.sv
// i2s_tx_framer
//
// Serialises stereo samples into a standard I2S stream (MSB first, one-bit
// delay after each lrck edge). Samples enter through a one-deep holding
// register with a valid/ready handshake; a new pair is pulled from it at
// every frame load.
//
// Handshake: a pair transfers on any cycle where sample_valid && sample_ready.
// sample_ready is high exactly when the holding register is empty and reset
// is low. The producer may change the pair only after it has transferred.
//
// Ports
//   i2s_sclk      in   the only clock
//   reset         in   synchronous, active-high
//   enable        in   frame generation enable (PLL locked)
//   left_in       in   SAMPLE_WIDTH left sample
//   right_in      in   SAMPLE_WIDTH right sample
//   sample_valid  in   left_in/right_in pair is valid
//   sample_ready  out  holding register is empty
//   bck           out  bit clock (registered)
//   lrck          out  word clock, 0 = left, 1 = right (registered)
//   sdata         out  serial data (registered)
//   frame_start   out  one-cycle pulse on every frame load
//   underrun      out  one-cycle pulse when a load finds the holder empty
//
// Build option
//   I2S_TX_UNDERRUN_REPEAT_EN : on underrun, retransmit the previously
//   loaded pair instead of zeros (zeros after reset).

module i2s_tx_framer #(
    parameter int SCLK_PER_BCK = 4,
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic                    i2s_sclk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    bck,
    output logic                    lrck,
    output logic                    sdata,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam int HALF = SCLK_PER_BCK / 2;
    localparam int DW   = (SCLK_PER_BCK > 1) ? $clog2(SCLK_PER_BCK) : 1;
    localparam int BW   = $clog2(2 * SLOT_WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           div_q, div_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [BW-1:0]           pos_d;
    logic                    load;
    logic                    bck_fall;
    logic                    in_data;
    logic                    accept;

    logic                    hold_full;
    logic [SAMPLE_WIDTH-1:0] hold_left, hold_right;
    logic [SAMPLE_WIDTH-1:0] left_sr, right_sr;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    logic [SAMPLE_WIDTH-1:0] prev_left, prev_right;
`endif

    assign sample_ready = !hold_full && !reset;
    assign accept       = sample_valid && sample_ready;

    // The IDLE->RUN load is treated like a bck falling edge at a frame
    // wrap, so every load leaves div_cnt = bit_cnt = 0 and frames are
    // spaced uniformly from the very first one.
    always_comb begin
        state_d  = state_q;
        div_d    = '0;
        bit_d    = '0;
        load     = 1'b0;
        bck_fall = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = RUN;
                    load     = 1'b1;
                    bck_fall = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (div_q == DW'(SCLK_PER_BCK - 1)) begin
                    bck_fall = 1'b1;
                    if (bit_q == BW'(2 * SLOT_WIDTH - 1)) begin
                        load = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                    bit_d = bit_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot position of the bit about to be driven; positions 1..SAMPLE_WIDTH
    // carry data, position 0 is the I2S delay bit, the rest is padding.
    always_comb begin
        pos_d   = (bit_d >= BW'(SLOT_WIDTH)) ? bit_d - BW'(SLOT_WIDTH) : bit_d;
        in_data = (pos_d != '0) && (pos_d <= BW'(SAMPLE_WIDTH));
    end

    always_ff @(posedge i2s_sclk) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            hold_full   <= 1'b0;
            hold_left   <= '0;
            hold_right  <= '0;
            left_sr     <= '0;
            right_sr    <= '0;
            bck         <= 1'b0;
            lrck        <= 1'b0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            prev_left   <= '0;
            prev_right  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            frame_start <= load;
            underrun    <= load && !hold_full;

            if (load) begin
                if (hold_full) begin
                    left_sr   <= hold_left;
                    right_sr  <= hold_right;
                    hold_full <= 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                    prev_left  <= hold_left;
                    prev_right <= hold_right;
`endif
                end else begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                    left_sr  <= prev_left;
                    right_sr <= prev_right;
`else
                    left_sr  <= '0;
                    right_sr <= '0;
`endif
                end
            end else if (bck_fall && in_data) begin
                if (bit_d < BW'(SLOT_WIDTH)) begin
                    left_sr <= left_sr << 1;
                end else begin
                    right_sr <= right_sr << 1;
                end
            end

            // An accept can only coincide with a load when the holder was
            // empty, so setting hold_full here correctly overrides nothing.
            if (accept) begin
                hold_left  <= left_in;
                hold_right <= right_in;
                hold_full  <= 1'b1;
            end

            if (state_d == RUN) begin
                bck <= (div_d >= DW'(HALF));
                if (bck_fall) begin
                    lrck <= (bit_d >= BW'(SLOT_WIDTH));
                    if (load || !in_data) begin
                        sdata <= 1'b0;
                    end else if (bit_d < BW'(SLOT_WIDTH)) begin
                        sdata <= left_sr[SAMPLE_WIDTH-1];
                    end else begin
                        sdata <= right_sr[SAMPLE_WIDTH-1];
                    end
                end
            end else begin
                bck   <= 1'b0;
                lrck  <= 1'b0;
                sdata <= 1'b0;
            end
        end
    end

endmodule
